// File: rtl/monster_hp_ctrl.sv
// Owns the monster HP register and applies one damage/heal update per req/ack request.
// Latency: ack the cycle after accept, new hp the cycle after that; bar length follows on frame_tick.
// Backpressure: reqs are held until acked; nothing is accepted in APPLY or FLASH, and nothing ever in DEAD.
module monster_hp_ctrl #(
  parameter int MAX_HP       = 150,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       round_start,
  input  logic       attack_req,
  input  logic [6:0] pangya_damage,
  output logic       attack_ack,
  input  logic       heal_req,
  input  logic [6:0] heal_amount,
  output logic       heal_ack,
  output logic [7:0] hp_value,
  output logic [7:0] hp_bar_len,
  output logic       hit_flash,
  output logic       monster_dead
);

  localparam logic [7:0] MAX_HP_L   = 8'(MAX_HP);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, FLASH, DEAD} state_t;

  state_t     state;
  logic [3:0] flash_cnt;
  logic       atk_arm;
  logic       heal_arm;
  logic [6:0] amt_q;
  logic       is_atk_q;

  logic [8:0] sum9;
  logic [8:0] dif9;
  logic [7:0] hp_new;

  // 9-bit arithmetic so both underflow and overflow past MAX_HP are visible before clamping
  always_comb begin
    sum9   = {1'b0, hp_value} + {2'b00, amt_q};
    dif9   = {1'b0, hp_value} - {2'b00, amt_q};
    hp_new = hp_value;
    if (is_atk_q) begin
      hp_new = dif9[8] ? 8'd0 : dif9[7:0];
    end else begin
      hp_new = (sum9 > {1'b0, MAX_HP_L}) ? MAX_HP_L : sum9[7:0];
    end
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      flash_cnt    <= 4'd0;
      atk_arm      <= 1'b1;
      heal_arm     <= 1'b1;
      amt_q        <= 7'd0;
      is_atk_q     <= 1'b0;
      attack_ack   <= 1'b0;
      heal_ack     <= 1'b0;
      hp_value     <= MAX_HP_L;
      hp_bar_len   <= MAX_HP_L;
      hit_flash    <= 1'b0;
      monster_dead <= 1'b0;
    end else if (round_start) begin
      // A new round discards any latched request without acking it
      state        <= IDLE;
      flash_cnt    <= 4'd0;
      atk_arm      <= 1'b1;
      heal_arm     <= 1'b1;
      attack_ack   <= 1'b0;
      heal_ack     <= 1'b0;
      hp_value     <= MAX_HP_L;
      hp_bar_len   <= MAX_HP_L;
      hit_flash    <= 1'b0;
      monster_dead <= 1'b0;
    end else begin
      attack_ack <= 1'b0;
      heal_ack   <= 1'b0;
      if (frame_tick) hp_bar_len <= hp_value;
      if (!attack_req) atk_arm <= 1'b1;
      if (!heal_req) heal_arm <= 1'b1;

      case (state)
        IDLE: begin
          if (attack_req && atk_arm) begin
            atk_arm    <= 1'b0;
            amt_q      <= pangya_damage;
            is_atk_q   <= 1'b1;
            attack_ack <= 1'b1;
            state      <= APPLY;
          end else if (heal_req && heal_arm) begin
            heal_arm <= 1'b0;
            amt_q    <= heal_amount;
            is_atk_q <= 1'b0;
            heal_ack <= 1'b1;
            state    <= APPLY;
          end
        end
        APPLY: begin
          hp_value <= hp_new;
          if (hp_new == 8'd0) begin
            monster_dead <= 1'b1;
            state        <= DEAD;
          end else if (is_atk_q && (amt_q != 7'd0)) begin
            hit_flash <= 1'b1;
            flash_cnt <= 4'd0;
            state     <= FLASH;
          end else begin
            state <= IDLE;
          end
        end
        FLASH: begin
          if (frame_tick) begin
            if (flash_cnt == FLASH_LAST) begin
              flash_cnt <= 4'd0;
              hit_flash <= 1'b0;
              state     <= IDLE;
            end else begin
              flash_cnt <= flash_cnt + 4'd1;
            end
          end
        end
        DEAD: begin
          state <= DEAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/monster_hp_ctrl.md
# monster_hp_ctrl

Sequencing controller for the monster HP bar. It owns the monster's hit-point register and accepts damage and heal requests from the battle logic through a req/ack handshake, applying exactly one update per request. It runs a post-hit flash/invulnerability window and publishes a frame-synchronous bar length and a defeat flag to the bar renderer. It sits between the attack/timing-bar logic and the HP-bar pixel generator, all in the 25 MHz pixel-clock domain.

## Interface
Parameters:
- MAX_HP, 150, full HP; also the full bar length in pixels (range 1..255).
- FLASH_FRAMES, 8, frames of the hit flash / invulnerability window (range 1..15).

Ports:
- Pclk  in  1  25 MHz pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame, at start of vertical blanking.
- round_start  in  1  one-cycle pulse; restores full HP and clears all state.
- attack_req  in  1  damage request, held until attack_ack.
- pangya_damage  in  7  damage amount; must be stable while attack_req is high.
- attack_ack  out  1  one-cycle pulse; the damage request was consumed.
- heal_req  in  1  heal request, held until heal_ack.
- heal_amount  in  7  heal amount; must be stable while heal_req is high.
- heal_ack  out  1  one-cycle pulse; the heal request was consumed.
- hp_value  out  8  live HP, 0..MAX_HP.
- hp_bar_len  out  8  displayed bar length in pixels; changes only on frame_tick.
- hit_flash  out  1  high during the flash window.
- monster_dead  out  1  high once HP reaches 0, until round_start.

## Operation
- States: IDLE, APPLY, FLASH, DEAD.
- Reset values:
  - hp_value = MAX_HP, hp_bar_len = MAX_HP.
  - attack_ack = heal_ack = hit_flash = monster_dead = 0.
  - State = IDLE, flash counter = 0, both arm flags = 1.
- Arm flags, one per requester:
  - Cleared when that request is accepted.
  - Set on any cycle its req is low.
  - A request is accepted only when its arm flag is 1. A req held high across several cycles therefore causes exactly one update.
- IDLE:
  - Armed attack_req: latch pangya_damage and go to APPLY.
  - Otherwise, armed heal_req: latch heal_amount and go to APPLY.
  - Attack has priority. A pending heal is served on a later IDLE cycle.
- APPLY, one cycle:
  - Attack: hp ← hp − dmg, saturating at 0. Pulse attack_ack.
  - Heal: hp ← hp + amount, saturating at MAX_HP. Pulse heal_ack.
  - Arithmetic is done 9 bits wide before saturation.
  - Next state:
    - DEAD if the new hp = 0.
    - FLASH if the update was an attack with dmg > 0.
    - IDLE otherwise, which covers heals and zero damage.
- FLASH:
  - hit_flash = 1. Counts frame_tick pulses.
  - After FLASH_FRAMES ticks: go to IDLE, clear the counter, drop hit_flash.
  - No request is accepted. Pending reqs wait, unacked.
- DEAD:
  - monster_dead = 1, hp_value = 0.
  - All requests are ignored and never acked.
- round_start, from any state:
  - Next cycle: hp = MAX_HP, state = IDLE, hit_flash = 0, monster_dead = 0, flash counter = 0, arm flags = 1.
  - Any latched request is discarded without ack.
  - hp_bar_len reloads to MAX_HP immediately, not waiting for frame_tick.
- hp_bar_len ← hp_value on every frame_tick. The renderer draws the bar from x0 to x0 + hp_bar_len.

## Timing
- Accept at edge N: state = APPLY in cycle N+1, with ack high only in cycle N+1.
- New hp_value is visible from cycle N+2. Latency from accept to hp change is 2 cycles.
- hit_flash / monster_dead rise in cycle N+2.
- Requester rule: drop req on the cycle ack is seen. Re-raising req re-arms only after at least one low cycle.
- frame_tick in the same cycle that hp changes: hp_bar_len takes the old value and updates on the next frame_tick.
- frame_tick on the APPLY cycle while entering FLASH is not counted. Counting starts in the first FLASH cycle.
- round_start coincident with a request: round_start wins, and no ack is issued.
- rst_n assertion mid-APPLY: all outputs return to reset values asynchronously, and no ack is emitted.

## Test plan
- Reset, then attack_req held for 20 cycles with damage 30:
  - Exactly one attack_ack.
  - hp_value = 120 two cycles after accept.
  - hit_flash high for 8 frame_ticks.
  - hp_bar_len = 120 after the next frame_tick.
- attack_req and heal_req raised in the same cycle (damage 10, heal 5):
  - Attack acked first; hp = 140.
  - Heal is held through FLASH, then acked; hp = 145.
- hp = 20, attack with damage 100:
  - hp saturates to 0; monster_dead = 1.
  - Further attack and heal reqs are never acked.
- hp = 145, heal 50: hp = 150, not 195; heal_ack once; no flash.
- Attack of 0: ack issued, hp unchanged, state returns to IDLE without flash.
- DEAD, then round_start:
  - Next cycle hp = 150, hp_bar_len = 150, monster_dead = 0.
  - An attack raised in the same cycle as round_start gets no ack.
